// File: rtl/mem_pkg.sv
// mem_pkg: shared access types, controller states and the alignment check.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_type_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        RESP
    } mem_state_e;

    // Type 2'b11 is reserved and always rejected, whatever the offset.
    function automatic logic misaligned(input logic [1:0] t, input logic [1:0] off);
        return (t == 2'b11) || (t == MEM_HALF && off[0]) || (t == MEM_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: pipeline request/response and data-RAM bus of the access controller.
interface mem_access_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [1:0]            req_type_i;
    logic                  req_unsigned_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  resp_valid_o;
    logic [DATA_WIDTH-1:0] resp_rdata_o;
    logic                  resp_err_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic                  ram_re_o;
    logic                  ram_we_o;
    logic [DATA_WIDTH-1:0] ram_wdata_o;
    logic [DATA_WIDTH-1:0] ram_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_type_i, req_unsigned_i, req_addr_i, req_wdata_i, ram_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, ram_addr_o, ram_re_o, ram_we_o, ram_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_type_i, req_unsigned_i, req_addr_i, req_wdata_i, ram_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o, ram_addr_o, ram_re_o, ram_we_o, ram_wdata_o
    );
endinterface

// File: rtl/mem_lane_merge.sv
// mem_lane_merge: sub-word store merge into an old RAM word, and load lane extract/extend.
module mem_lane_merge
    import mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  mem_type_e   mtype,
    input  logic [1:0]  off,
    input  logic        is_unsigned,
    output logic [31:0] merged,
    output logic [31:0] load_data
);
    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] lane;

    assign sh   = (mtype == MEM_BYTE) ? {off, 3'b000} : (mtype == MEM_HALF) ? {off[1], 4'b0000} : 5'd0;
    assign mask = (mtype == MEM_BYTE) ? 32'h0000_00ff : (mtype == MEM_HALF) ? 32'h0000_ffff : 32'hffff_ffff;

    assign merged = (old_word & ~(mask << sh)) | ((wdata & mask) << sh);
    assign lane   = (old_word >> sh) & mask;

    assign load_data = (mtype == MEM_BYTE) ? {{24{~is_unsigned & lane[7]}}, lane[7:0]} :
                       (mtype == MEM_HALF) ? {{16{~is_unsigned & lane[15]}}, lane[15:0]} : lane;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores onto a single-port sync-read RAM (RMW for sub-word stores).
// Define MEM_ACCESS_CTRL_PERF_EN to add load/store/error performance counters.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    mem_access_ctrl_if.slave bus
`ifdef MEM_ACCESS_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_loads_o,
    output logic [31:0]     perf_stores_o,
    output logic [31:0]     perf_errs_o
`endif
);
    mem_state_e            state, state_n;
    logic                  we_q;
    logic [1:0]            type_q;
    logic                  uns_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  accept;

    assign accept = bus.req_valid_i && state == IDLE;

    // Error and store paths never reach WAIT with type 2'b11, so the cast is safe.
    mem_lane_merge u_lane (
        .old_word    (bus.ram_rdata_i),
        .wdata       (wdata_q),
        .mtype       (mem_type_e'(type_q)),
        .off         (addr_q[1:0]),
        .is_unsigned (uns_q),
        .merged      (merged),
        .load_data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            type_q  <= 2'b00;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                we_q    <= bus.req_we_i;
                type_q  <= bus.req_type_i;
                uns_q   <= bus.req_unsigned_i;
                err_q   <= misaligned(bus.req_type_i, bus.req_addr_i[1:0]);
                addr_q  <= bus.req_addr_i;
                wdata_q <= bus.req_wdata_i;
                rdata_q <= '0;
            end
            if (state == WAIT) begin
                if (we_q) wdata_q <= merged;
                else      rdata_q <= load_data;
            end
        end
    end

    always_comb begin
        state_n          = state;
        bus.req_ready_o  = state == IDLE;
        bus.resp_valid_o = state == RESP;
        bus.resp_err_o   = state == RESP && err_q;
        bus.resp_rdata_o = (state == RESP) ? rdata_q : '0;
        bus.ram_addr_o   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        bus.ram_re_o     = !rst && state == RD;
        bus.ram_we_o     = !rst && state == WR;
        bus.ram_wdata_o  = (state == WR) ? wdata_q : '0;
        case (state)
            IDLE: if (accept)
                      state_n = misaligned(bus.req_type_i, bus.req_addr_i[1:0]) ? RESP :
                                (bus.req_we_i && bus.req_type_i == MEM_WORD) ? WR : RD;
            RD:      state_n = WAIT;
            WAIT:    state_n = we_q ? WR : RESP;
            WR:      state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

`ifdef MEM_ACCESS_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_loads_o  <= '0;
            perf_stores_o <= '0;
            perf_errs_o   <= '0;
        end else if (state == RESP) begin
            if (err_q)     perf_errs_o   <= perf_errs_o + 32'd1;
            else if (we_q) perf_stores_o <= perf_stores_o + 32'd1;
            else           perf_loads_o  <= perf_loads_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl with a behavioural sync-read RAM.
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef MEM_ACCESS_CTRL_PERF_EN
    logic [31:0] perf_loads, perf_stores, perf_errs;
    mem_access_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave),
                         .perf_loads_o(perf_loads), .perf_stores_o(perf_stores), .perf_errs_o(perf_errs));
`else
    mem_access_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] ram     [0:255];
    logic [31:0] ref_mem [0:255];
    int          cyc = 0, total = 0, bad = 0, n_re = 0, n_we = 0, last_resp = -1, last_acc = 0;
    int          r0, w0;
    logic [31:0] last_wdata = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.ram_we_o) ram[bus.ram_addr_o[9:2]] <= bus.ram_wdata_o;
        if (bus.ram_re_o) bus.ram_rdata_i <= ram[bus.ram_addr_o[9:2]];
    end

    always @(negedge clk) begin
        if (bus.ram_re_o) n_re++;
        if (bus.ram_we_o) begin
            n_we++;
            last_wdata = bus.ram_wdata_o;
        end
        if (bus.ram_re_o || bus.ram_we_o) chk("strobe_excl", {31'b0, bus.ram_re_o & bus.ram_we_o}, 0);
        if (bus.resp_valid_o) begin
            chk("resp_expected", {31'b0, sbq.size() != 0}, 1);
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                chk("rdata", bus.resp_rdata_o, mon_e.rdata);
                chk("err", {31'b0, bus.resp_err_o}, {31'b0, mon_e.err});
                chk("latency", cyc - mon_e.acc, mon_e.lat);
            end
            last_resp = cyc;
        end
    end

    task automatic issue(input logic we, input logic [1:0] t, input logic uns, input logic [31:0] a, input logic [31:0] wd);
        int         n;
        int         w;
        exp_t       e;
        logic [7:0] bt [4];
        logic [7:0] v8;
        logic [15:0] v16;
        n = 0;
        w = int'(a[9:2]);
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_type_i     = t;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = a;
        bus.req_wdata_i    = wd;
        while (!bus.req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", {31'b0, n < 50}, 1);
        last_acc = cyc;
        e.acc    = cyc;
        e.err    = (t == 2'd3) || (t == 2'd1 && a[0]) || (t == 2'd2 && a[1:0] != 2'd0);
        e.rdata  = '0;
        for (int i = 0; i < 4; i++) bt[i] = ref_mem[w][8*i +: 8];
        if (!e.err && we) begin
            if (t == 2'd0) bt[a[1:0]] = wd[7:0];
            else if (t == 2'd1) begin
                bt[{a[1], 1'b0}] = wd[7:0];
                bt[{a[1], 1'b1}] = wd[15:8];
            end else for (int i = 0; i < 4; i++) bt[i] = wd[8*i +: 8];
            ref_mem[w] = {bt[3], bt[2], bt[1], bt[0]};
        end else if (!e.err) begin
            if (t == 2'd0) begin
                v8 = bt[a[1:0]];
                e.rdata = uns ? {24'b0, v8} : {{24{v8[7]}}, v8};
            end else if (t == 2'd1) begin
                v16 = {bt[{a[1], 1'b1}], bt[{a[1], 1'b0}]};
                e.rdata = uns ? {16'b0, v16} : {{16{v16[15]}}, v16};
            end else e.rdata = {bt[3], bt[2], bt[1], bt[0]};
        end
        e.lat = e.err ? 1 : (we && t == 2'd2) ? 2 : we ? 4 : 3;
        sbq.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
        chk("drain", sbq.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        ram[64]            = 32'hAABB_CCDD;
        ref_mem[64]        = 32'hAABB_CCDD;
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_type_i     = 2'b00;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = '0;
        bus.req_wdata_i    = '0;
        bus.ram_rdata_i    = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, bus.req_ready_o}, 1);
        chk("rst_resp_valid", {31'b0, bus.resp_valid_o}, 0);
        chk("rst_resp_err", {31'b0, bus.resp_err_o}, 0);
        chk("rst_re", {31'b0, bus.ram_re_o}, 0);
        chk("rst_we", {31'b0, bus.ram_we_o}, 0);
        chk("rst_rdata", bus.resp_rdata_o, 0);
        chk("rst_addr", bus.ram_addr_o, 0);
        chk("rst_wdata", bus.ram_wdata_o, 0);
        rst = 1'b0;

        issue(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
        idle();

        r0 = n_re; w0 = n_we;
        issue(1'b1, 2'd0, 1'b0, 32'h102, 32'h11);
        idle();
        chk("sb_wdata", last_wdata, 32'hAA11_CCDD);
        chk("sb_re", n_re - r0, 1);
        chk("sb_we", n_we - w0, 1);

        r0 = n_re; w0 = n_we;
        issue(1'b1, 2'd2, 1'b0, 32'h104, 32'h1234_5678);
        idle();
        chk("sw_re", n_re - r0, 0);
        chk("sw_we", n_we - w0, 1);
        issue(1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
        idle();

        r0 = n_re; w0 = n_we;
        issue(1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h103, 32'hBEEF);
        issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
        idle();
        chk("err_strobes", (n_re - r0) + (n_we - w0), 0);

        w0 = n_we;
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = 1'b1;
        bus.req_type_i     = 2'd1;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 32'h100;
        bus.req_wdata_i    = 32'hBEEF;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", {31'b0, bus.req_ready_o}, 1);
        chk("midrst_resp", {31'b0, bus.resp_valid_o}, 0);
        repeat (5) @(negedge clk);
        chk("midrst_we", n_we - w0, 0);
        chk("midrst_ram", ram[64], ref_mem[64]);

        issue(1'b1, 2'd0, 1'b0, 32'h105, 32'h9C);
        issue(1'b0, 2'd0, 1'b0, 32'h105, 32'h0);
        chk("b2b_gap", last_acc, last_resp + 1);
        idle();

        repeat (40)
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  32'h100 + 32'($urandom_range(0, 15)), $urandom);
        idle();

        for (int i = 64; i < 68; i++) chk("ram_word", ram[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences pipeline load/store requests onto the single-port, synchronous-read data RAM.
- Word stores: written directly.
- Byte/halfword stores: read-modify-write (read word, merge lane, write back).
- Loads: extracts the addressed lane, then zero- or sign-extends it.
- Sits between the MEM stage and data RAM. The pipeline stalls while req_ready_o is low.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, RAM word width (only 32 supported)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_i  in  1  request present
req_ready_o  out  1  request accepted this cycle when valid&ready
req_we_i  in  1  1 = store, 0 = load
req_type_i  in  2  00 byte, 01 halfword, 10 word, 11 reserved
req_unsigned_i  in  1  load zero-extend (LBU/LHU)
req_addr_i  in  ADDR_WIDTH  byte address
req_wdata_i  in  DATA_WIDTH  store data, right-aligned
resp_valid_o  out  1  one-cycle completion pulse
resp_rdata_o  out  DATA_WIDTH  extended load data (0 for stores/errors)
resp_err_o  out  1  misaligned/reserved access, valid with resp_valid_o
ram_addr_o  out  ADDR_WIDTH  word-aligned address {addr[31:2],2'b00}
ram_re_o  out  1  RAM read strobe; data on ram_rdata_i next cycle
ram_we_o  out  1  RAM write strobe
ram_wdata_o  out  DATA_WIDTH  full word to write
ram_rdata_i  in  DATA_WIDTH  RAM read data

Behaviour:
- FSM states: IDLE, RD, WAIT, WR, RESP.
- Reset state: IDLE. Reset values: req_ready_o=1; resp_valid_o, resp_err_o, ram_re_o, ram_we_o=0; resp_rdata_o, ram_addr_o, ram_wdata_o=0.
- IDLE: req_ready_o=1; all other states drive it 0. On valid&ready, latch we, type, unsigned, addr and wdata.
- Accept-cycle transitions out of IDLE:
  - Error (half with addr[0]=1; word with addr[1:0]!=0; type 11) -> RESP. No RAM strobe.
  - Word store -> WR.
  - Any load or sub-word store -> RD.
- RD: ram_re_o=1 with latched word address -> WAIT.
- WAIT: capture ram_rdata_i.
  - Load: extract lane at addr[1:0] (byte) or addr[1] (half), extend per unsigned, -> RESP.
  - Sub-word store: merge wdata[7:0] or wdata[15:0] into the lane, leave other bytes unchanged -> WR.
- WR: ram_we_o=1 with the full or merged word -> RESP.
- RESP: resp_valid_o=1 for exactly one cycle, resp_err_o as computed -> IDLE unconditionally. There is no response backpressure.
- Latency, accept edge to resp_valid_o:
  - error: 1 cycle
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
- Throughput: next accept is possible the cycle after RESP.
- ram_re_o and ram_we_o are never both high.
- Both RAM strobes are gated by !rst, so no write commits in a cycle where rst=1.
- Reset mid-operation: return to IDLE next edge and discard the request. No response is issued.
- req_valid_i held high while not ready is ignored. The latched request stays stable until RESP.

Optional Feature:
MEM_ACCESS_CTRL_PERF_EN
- Defined: adds ports perf_loads_o, perf_stores_o and perf_errs_o (32 bits each).
  - Each counter increments in RESP for its category.
  - Counters reset to 0 and wrap at 2^32.
- Undefined: no ports, no counter logic.

Decomposition:
- Package mem_pkg holds:
  - mem_type_e (MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10)
  - the FSM state enum
  - the misalign check function
- Sub-module mem_lane_merge: combinational store merge (old word, wdata, type, offset -> new word) plus load extract/extend. The FSM lives in mem_access_ctrl.

Test Plan:
- RAM[0x100]=0xAABBCCDD; SB 0x11 @0x102 -> RD, WR with ram_wdata_o=0xAA11CCDD; resp_valid_o 4 cycles after accept, err=0.
- Same word; LH signed @0x102 -> resp_rdata_o=0xFFFFAABB. LBU @0x103 -> 0x000000AA. Each arrives 3 cycles after accept.
- SW 0x12345678 @0x104 -> no ram_re_o, ram_we_o in cycle +1, resp at +2; read back LW = 0x12345678.
- LW @0x101 and SH @0x103 -> resp_err_o=1 at +1, no ram_re_o/ram_we_o, resp_rdata_o=0.
- SH 0xBEEF @0x100 with rst pulsed during WAIT -> ram_we_o never asserts, no resp_valid_o, RAM unchanged, req_ready_o=1 after reset.
- Back-to-back valid held high for SB then LB -> second accepted only in the cycle after first RESP, and returns the merged byte.
